// File: rtl/obf_key_pkg.sv
// Shared types and limits for the obfuscation key loader.
// Related macro: KEY_LOCKOUT_EN (consumed by obf_key_loader).
package obf_key_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CHECK   = 3'd2,
    ARMED   = 3'd3,
    LOCKOUT = 3'd4
  } state_t;

  localparam int FAIL_CNT_W = 4;
  localparam int KEY_W_MAX  = 64;

endpackage

// File: rtl/obf_key_shifter.sv
// Serial-in key capture: LSB-first shift register, bit counter and running parity.
// at_parity marks that the next accepted bit is the trailing parity bit.
module obf_key_shifter
  import obf_key_pkg::*;
#(
  parameter int KEY_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shreg,
  output logic             parity,
  output logic             at_parity
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  logic [CNT_W-1:0] bit_cnt;

  if (KEY_W < 1 || KEY_W > KEY_W_MAX) begin : g_bad_key_w
    illegal_key_w_parameter u_bad ();
  end

  assign at_parity = (bit_cnt == CNT_W'(KEY_W));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg   <= '0;
      bit_cnt <= '0;
      parity  <= 1'b0;
    end else if (shift_en) begin
      // Loop-compare instead of a variable index keeps the select in range for any KEY_W.
      for (int i = 0; i < KEY_W; i++) begin
        if (bit_cnt == CNT_W'(i)) shreg[i] <= bit_in;
      end
      parity  <= parity ^ bit_in;
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/obf_key_loader.sv
// Verified key delivery to the locked c499 netlist; drives DEFAULT_KEY until a load passes parity.
// Optional macro KEY_LOCKOUT_EN: after MAX_FAIL consecutive parity failures, lock until reset.
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int               KEY_W       = 2,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = '0,
  parameter int               MAX_FAIL    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             key_bit_valid,
  input  logic             key_bit,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy,
  output logic             locked_out
);

  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
    illegal_max_fail_parameter u_bad ();
  end

  state_t                  state, state_nxt;
  logic [KEY_W-1:0]        key_reg;
  logic [FAIL_CNT_W-1:0]   fail_cnt, fail_cnt_inc;
  logic                    sh_clear, sh_shift, load_go, check_pass, check_fail;
  logic [KEY_W-1:0]        sh_key;
  logic                    sh_parity, sh_at_parity;

  obf_key_shifter #(.KEY_W(KEY_W)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .clear     (sh_clear),
    .shift_en  (sh_shift),
    .bit_in    (key_bit),
    .shreg     (sh_key),
    .parity    (sh_parity),
    .at_parity (sh_at_parity)
  );

  assign fail_cnt_inc = (fail_cnt == FAIL_CNT_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + FAIL_CNT_W'(1);

  always_comb begin
    state_nxt  = state;
    sh_clear   = 1'b0;
    sh_shift   = 1'b0;
    load_go    = 1'b0;
    check_pass = 1'b0;
    check_fail = 1'b0;
    case (state)
      IDLE, ARMED: begin
        if (load_start) begin
          state_nxt = SHIFT;
          sh_clear  = 1'b1;
          load_go   = 1'b1;
        end
      end
      SHIFT: begin
        // A restart request beats a bit presented in the same cycle.
        if (load_start) begin
          sh_clear = 1'b1;
        end else if (key_bit_valid) begin
          sh_shift = 1'b1;
          if (sh_at_parity) state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (!sh_parity) begin
          check_pass = 1'b1;
          state_nxt  = ARMED;
        end else begin
          check_fail = 1'b1;
          state_nxt  = IDLE;
`ifdef KEY_LOCKOUT_EN
          if (fail_cnt_inc == FAIL_CNT_W'(MAX_FAIL)) state_nxt = LOCKOUT;
`endif
        end
      end
      LOCKOUT: begin
`ifdef KEY_LOCKOUT_EN
        state_nxt = LOCKOUT;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= DEFAULT_KEY;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (load_go) begin
        key_reg   <= DEFAULT_KEY;
        key_valid <= 1'b0;
        key_err   <= 1'b0;
      end
      if (check_pass) begin
        key_reg   <= sh_key;
        key_valid <= 1'b1;
        fail_cnt  <= '0;
      end
      if (check_fail) begin
        key_err  <= 1'b1;
        fail_cnt <= fail_cnt_inc;
      end
    end
  end

  assign key_out       = key_reg;
  assign key_bit_ready = (state == SHIFT);
  assign busy          = (state == SHIFT) || (state == CHECK);
`ifdef KEY_LOCKOUT_EN
  assign locked_out    = (state == LOCKOUT);
`else
  assign locked_out    = 1'b0;
`endif

endmodule
